csr_machine_unit: RTL and testbench

Parametrised machine-mode CSR unit for the VanilaCore RV32 pipeline. It executes the Zicsr instructions (CSRRW/RS/RC and their immediate forms) and holds the machine trap CSRs and the cycle/instret counters. It arbitrates exceptions, interrupts and MRET, and issues a registered PC redirect to fetch. It sits beside the execute stage, and the core drives it once per retiring instruction.

---
 rtl/csr_machine_unit.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_csr_machine_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_machine_unit.sv
// csr_machine_unit
// Machine-mode CSR unit for an RV32 core. Executes the Zicsr instructions
// (CSRRW/RS/RC and their immediate forms). Holds the machine trap CSRs and the
// cycle/instret counters. Arbitrates exceptions, interrupts and MRET, and
// issues a registered one-cycle PC redirect to fetch.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   csr_en/csr_op/csr_addr/rs1_data/src_idx
//                       CSR instruction executing this cycle
//   rd_data, illegal    combinational old value / illegal-access flag
//   instret             one instruction retired this cycle
//   exc_valid/exc_cause/exc_pc/exc_tval
//                       synchronous exception (exc_pc also names the
//                       interrupted instruction)
//   irq_ok              core may take an interrupt this cycle
//   mret                MRET executing
//   meip, msip, mtip    level interrupt inputs
//   redirect_valid/redirect_pc
//                       registered fetch redirect, high for one cycle
module csr_machine_unit #(
  parameter int          XLEN        = 32,
  parameter int          COUNTER_W   = 64,
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_en,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  src_idx,
  output logic [31:0] rd_data,
  output logic        illegal,
  input  logic        instret,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        irq_ok,
  input  logic        mret,
  input  logic        meip,
  input  logic        msip,
  input  logic        mtip,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("csr_machine_unit: only XLEN=32 is supported");
    end
    if (COUNTER_W < 32 || COUNTER_W > 64) begin : g_bad_counter_w
      $error("csr_machine_unit: COUNTER_W must be in 32..64");
    end
  endgenerate

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
  // With vectoring disabled the MODE field must come out of reset as 0 too.
  localparam logic [31:0] MTVEC_INIT = VECTORED_EN ? MTVEC_RST
                                                   : {MTVEC_RST[31:2], 2'b00};

  // Architectural state
  logic                 st_mie_reg;
  logic                 st_mpie_reg;
  logic [31:0]          mie_reg;
  logic [31:0]          mtvec_reg;
  logic [31:0]          mscratch_reg;
  logic [31:0]          mepc_reg;
  logic [31:0]          mcause_reg;
  logic [31:0]          mtval_reg;
  logic [COUNTER_W-1:0] mcycle_reg;
  logic [COUNTER_W-1:0] minstret_reg;
  logic [COUNTER_W-1:0] mcycle_next;
  logic [COUNTER_W-1:0] minstret_next;

  // Counters viewed as 64 bits so high-half reads and writes need no
  // special casing when COUNTER_W=32 (upper bits read as zero and high-half
  // writes are discarded on truncation).
  logic [63:0] cyc_ext;
  logic [63:0] ins_ext;
  logic [63:0] cyc_ext_next;
  logic [63:0] ins_ext_next;

  assign cyc_ext = 64'(mcycle_reg);
  assign ins_ext = 64'(minstret_reg);

  logic [31:0] mstatus_val;
  logic [31:0] mip_val;

  assign mstatus_val = {19'b0, 2'b11, 3'b0, st_mpie_reg, 3'b0, st_mie_reg, 3'b0};
  assign mip_val     = {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};

  // ---------------------------------------------------------------------------
  // Read mux and access legality
  // ---------------------------------------------------------------------------
  logic [31:0] old_val;
  logic        known_addr;

  always_comb begin
    old_val    = '0;
    known_addr = 1'b1;
    case (csr_addr)
      A_MSTATUS:               old_val = mstatus_val;
      A_MISA:                  old_val = MISA_VAL;
      A_MIE:                   old_val = mie_reg;
      A_MTVEC:                 old_val = mtvec_reg;
      A_MSCRATCH:              old_val = mscratch_reg;
      A_MEPC:                  old_val = mepc_reg;
      A_MCAUSE:                old_val = mcause_reg;
      A_MTVAL:                 old_val = mtval_reg;
      A_MIP:                   old_val = mip_val;
      A_MCYCLE, A_CYCLE:       old_val = cyc_ext[31:0];
      A_MCYCLEH, A_CYCLEH:     old_val = cyc_ext[63:32];
      A_MINSTRET, A_INSTRET:   old_val = ins_ext[31:0];
      A_MINSTRETH, A_INSTRETH: old_val = ins_ext[63:32];
      A_MHARTID:               old_val = HART_ID;
      default:                 known_addr = 1'b0;
    endcase
  end

  assign rd_data = old_val;

  logic [31:0] src_val;
  logic [31:0] wr_val;
  logic        op_legal;
  logic        wants_write;

  assign src_val  = csr_op[2] ? {27'b0, src_idx} : rs1_data;
  assign op_legal = (csr_op[1:0] != 2'b00);
  // Set/clear forms with a zero source are pure reads.
  assign wants_write = (csr_op[1:0] == 2'b01) || (src_idx != 5'd0);

  always_comb begin
    case (csr_op[1:0])
      2'b10:   wr_val = old_val | src_val;
      2'b11:   wr_val = old_val & ~src_val;
      default: wr_val = src_val;
    endcase
  end

  assign illegal = csr_en & (~known_addr | ~op_legal |
                             (wants_write & (csr_addr[11:10] == 2'b11)));

  // ---------------------------------------------------------------------------
  // Event arbitration: exception > interrupt > mret > CSR write
  // ---------------------------------------------------------------------------
  logic [31:0] irq_pend;
  logic [3:0]  irq_code;
  logic        irq_take;
  logic        mret_take;
  logic        trap_take;
  logic        csr_we;

  assign irq_pend  = mie_reg & mip_val;
  assign irq_take  = ~exc_valid & irq_ok & st_mie_reg & (|irq_pend);
  assign mret_take = ~exc_valid & ~irq_take & mret;
  assign trap_take = exc_valid | irq_take;
  assign csr_we    = csr_en & ~illegal & wants_write & ~trap_take & ~mret_take;

  always_comb begin
    if (irq_pend[11])     irq_code = 4'd11;
    else if (irq_pend[3]) irq_code = 4'd3;
    else                  irq_code = 4'd7;
  end

  logic [31:0] trap_cause;
  logic [31:0] trap_target;

  assign trap_cause  = irq_take ? {1'b1, 27'b0, irq_code} : {28'b0, exc_cause};
  // Vectored mode offsets only interrupts, by 4*cause.
  assign trap_target = {mtvec_reg[31:2], 2'b00} +
                       ((irq_take && (mtvec_reg[1:0] == 2'b01)) ?
                        {26'b0, irq_code, 2'b00} : 32'b0);

  // MODE only accepts the encodings we implement; anything else keeps it.
  logic [1:0] mtvec_mode_next;
  assign mtvec_mode_next = (VECTORED_EN && (wr_val[1:0] <= 2'b01)) ?
                           wr_val[1:0] : mtvec_reg[1:0];

  // ---------------------------------------------------------------------------
  // Counters: a write to either half replaces it and drops that cycle's
  // increment for the whole counter.
  // ---------------------------------------------------------------------------
  logic we_cyc_lo;
  logic we_cyc_hi;
  logic we_ins_lo;
  logic we_ins_hi;

  assign we_cyc_lo = csr_we && (csr_addr == A_MCYCLE);
  assign we_cyc_hi = csr_we && (csr_addr == A_MCYCLEH) && (COUNTER_W > 32);
  assign we_ins_lo = csr_we && (csr_addr == A_MINSTRET);
  assign we_ins_hi = csr_we && (csr_addr == A_MINSTRETH) && (COUNTER_W > 32);

  always_comb begin
    cyc_ext_next = cyc_ext + 64'd1;
    if (we_cyc_lo || we_cyc_hi) begin
      cyc_ext_next = cyc_ext;
      if (we_cyc_lo) cyc_ext_next[31:0]  = wr_val;
      if (we_cyc_hi) cyc_ext_next[63:32] = wr_val;
    end
  end

  always_comb begin
    ins_ext_next = ins_ext + {63'b0, instret};
    if (we_ins_lo || we_ins_hi) begin
      ins_ext_next = ins_ext;
      if (we_ins_lo) ins_ext_next[31:0]  = wr_val;
      if (we_ins_hi) ins_ext_next[63:32] = wr_val;
    end
  end

  assign mcycle_next   = cyc_ext_next[COUNTER_W-1:0];
  assign minstret_next = ins_ext_next[COUNTER_W-1:0];

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_mie_reg     <= 1'b0;
      st_mpie_reg    <= 1'b0;
      mie_reg        <= '0;
      mtvec_reg      <= MTVEC_INIT;
      mscratch_reg   <= '0;
      mepc_reg       <= '0;
      mcause_reg     <= '0;
      mtval_reg      <= '0;
      mcycle_reg     <= '0;
      minstret_reg   <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      mcycle_reg     <= mcycle_next;
      minstret_reg   <= minstret_next;
      redirect_valid <= trap_take | mret_take;
      if (trap_take) begin
        mepc_reg    <= exc_pc & ~32'h3;
        mcause_reg  <= trap_cause;
        mtval_reg   <= irq_take ? 32'h0 : exc_tval;
        st_mpie_reg <= st_mie_reg;
        st_mie_reg  <= 1'b0;
        redirect_pc <= trap_target;
      end else if (mret_take) begin
        st_mie_reg  <= st_mpie_reg;
        st_mpie_reg <= 1'b1;
        redirect_pc <= mepc_reg;
      end else if (csr_we) begin
        case (csr_addr)
          A_MSTATUS: begin
            st_mie_reg  <= wr_val[3];
            st_mpie_reg <= wr_val[7];
          end
          A_MIE:      mie_reg      <= wr_val & MIE_MASK;
          A_MTVEC:    mtvec_reg    <= {wr_val[31:2], mtvec_mode_next};
          A_MSCRATCH: mscratch_reg <= wr_val;
          A_MEPC:     mepc_reg     <= wr_val & ~32'h3;
          A_MCAUSE:   mcause_reg   <= wr_val;
          A_MTVAL:    mtval_reg    <= wr_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_machine_unit.sv
// tb_csr_machine_unit
// Self-checking bench for csr_machine_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the CSR file.
module tb_csr_machine_unit;

  localparam logic [31:0] HART    = 32'h0000_0005;
  localparam logic [31:0] MTV_RST = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_en;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  src_idx;
  logic [31:0] rd_data;
  logic        illegal;
  logic        instret;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        irq_ok;
  logic        mret;
  logic        meip, msip, mtip;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  csr_machine_unit #(
    .XLEN(32), .COUNTER_W(64), .HART_ID(HART), .MTVEC_RST(MTV_RST), .VECTORED_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .src_idx(src_idx), .rd_data(rd_data), .illegal(illegal),
    .instret(instret), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .irq_ok(irq_ok), .mret(mret), .meip(meip), .msip(msip),
    .mtip(mtip), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // ---------------- behavioural model ----------------
  bit [31:0] m_reg [int];   // mie, mtvec, mscratch, mepc, mcause, mtval by address
  bit        m_mie, m_mpie;
  bit [63:0] m_cyc, m_ins;
  bit        m_rv;
  bit [31:0] m_rpc;

  task automatic model_reset();
    m_reg[12'h304] = 32'h0;
    m_reg[12'h305] = MTV_RST;
    m_reg[12'h340] = 32'h0;
    m_reg[12'h341] = 32'h0;
    m_reg[12'h342] = 32'h0;
    m_reg[12'h343] = 32'h0;
    m_mie = 1'b0; m_mpie = 1'b0;
    m_cyc = 64'd0; m_ins = 64'd0;
    m_rv = 1'b0; m_rpc = 32'h0;
  endtask

  function automatic bit [31:0] mip_now();
    return {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
  endfunction

  function automatic bit implemented(bit [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
      12'hC82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] m_read(bit [11:0] a);
    case (a)
      12'h300: return {19'b0, 2'b11, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
      12'h301: return 32'h4000_0100;
      12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343: return m_reg[a];
      12'h344: return mip_now();
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_wants_write();
    return (csr_op == 3'd1) || (csr_op == 3'd5) || (src_idx != 5'd0);
  endfunction

  function automatic bit exp_illegal();
    bit [11:0] a;
    a = csr_addr;
    return csr_en && (!implemented(a) || csr_op == 3'd0 || csr_op == 3'd4 ||
                      (m_wants_write() && a[11:10] == 2'b11));
  endfunction

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_step();
    bit [31:0] src, old, nv, pend, mtv;
    bit        intr;
    bit [3:0]  code;
    bit [63:0] ncyc, nins;
    src  = csr_op[2] ? {27'b0, src_idx} : rs1_data;
    old  = m_read(csr_addr);
    pend = m_reg[12'h304] & mip_now();
    intr = !exc_valid && irq_ok && m_mie && (pend != 0);
    code = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
    mtv  = m_reg[12'h305];
    ncyc = m_cyc + 64'd1;
    nins = m_ins + (instret ? 64'd1 : 64'd0);
    m_rv = 1'b0;
    if (exc_valid || intr) begin
      m_reg[12'h341] = exc_pc & ~32'h3;
      m_reg[12'h342] = intr ? (32'h8000_0000 | 32'(code)) : 32'(exc_cause);
      m_reg[12'h343] = intr ? 32'h0 : exc_tval;
      m_mpie = m_mie;
      m_mie  = 1'b0;
      m_rv   = 1'b1;
      m_rpc  = (mtv & ~32'h3) + ((intr && mtv[1:0] == 2'd1) ? 32'(code) * 4 : 32'h0);
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1'b1;
      m_rv   = 1'b1;
      m_rpc  = m_reg[12'h341];
    end else if (csr_en && m_wants_write() && !exp_illegal()) begin
      case (csr_op[1:0])
        2'd2:    nv = old | src;
        2'd3:    nv = old & ~src;
        default: nv = src;
      endcase
      case (csr_addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_reg[12'h304] = nv & 32'h888;
        12'h305: m_reg[12'h305] = {nv[31:2], (nv[1:0] <= 2'd1) ? nv[1:0] : mtv[1:0]};
        12'h340, 12'h342, 12'h343: m_reg[csr_addr] = nv;
        12'h341: m_reg[12'h341] = nv & ~32'h3;
        12'hB00: ncyc = {m_cyc[63:32], nv};
        12'hB80: ncyc = {nv, m_cyc[31:0]};
        12'hB02: nins = {m_ins[63:32], nv};
        12'hB82: nins = {nv, m_ins[31:0]};
        default: ;
      endcase
    end
    m_cyc = ncyc;
    m_ins = nins;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit ill;
      ill = exp_illegal();
      check("illegal", 32'(illegal), 32'(ill));
      if (csr_en && !ill) check("rd_data", rd_data, m_read(csr_addr));
      check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
      if (m_rv) check("redirect_pc", redirect_pc, m_rpc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    csr_en = 1'b0; csr_op = 3'd0; csr_addr = 12'h0; rs1_data = 32'h0; src_idx = 5'd0;
    instret = 1'b0; exc_valid = 1'b0; exc_cause = 4'd0; exc_pc = 32'h0; exc_tval = 32'h0;
    irq_ok = 1'b0; mret = 1'b0; meip = 1'b0; msip = 1'b0; mtip = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    #1;
    idle();
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] a,
                     input logic [31:0] v, input logic [4:0] idx);
    csr_en = 1'b1; csr_op = op; csr_addr = a; rs1_data = v; src_idx = idx;
  endtask

  task automatic rd(input logic [11:0] a);
    csr(3'd2, a, 32'h0, 5'd0);
  endtask

  bit [11:0] addrs [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                            12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                            12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                            12'h7FF, 12'h345, 12'h306};

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Reset values
    rd(12'h305); #2;
    check("rst_mtvec", rd_data, 32'h0000_0100);
    check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    tick();
    rd(12'h301); #2; check("misa", rd_data, 32'h4000_0100); tick();
    rd(12'hF14); #2; check("mhartid", rd_data, 32'h5); tick();

    // mscratch RW / RS-no-write / RCI
    csr(3'd1, 12'h340, 32'hDEAD_BEEF, 5'd7); tick();
    rd(12'h340); #2; check("mscratch_rw", rd_data, 32'hDEAD_BEEF); tick();
    csr(3'd7, 12'h340, 32'h0, 5'h0F); #2; check("rci_old", rd_data, 32'hDEAD_BEEF); tick();
    rd(12'h340); #2; check("mscratch_rci", rd_data, 32'hDEAD_BEE0); tick();

    // Illegal accesses
    csr(3'd1, 12'hC00, 32'h55, 5'd1); #2; check("ill_wr_ro", 32'(illegal), 32'h1); tick();
    rd(12'h7FF); #2; check("ill_unimpl", 32'(illegal), 32'h1); tick();
    csr(3'd4, 12'h340, 32'h1, 5'd1); #2; check("ill_op4", 32'(illegal), 32'h1); tick();
    rd(12'hC00); #2; check("cycle_read_legal", 32'(illegal), 32'h0); tick();

    // Exception with a concurrent CSR write that must be dropped
    csr(3'd1, 12'h305, 32'h200, 5'd1); tick();
    csr(3'd1, 12'h340, 32'h1234, 5'd1);
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'h13;
    tick();
    rd(12'h341); #2;
    check("exc_rv", 32'(redirect_valid), 32'h1);
    check("exc_rpc", redirect_pc, 32'h200);
    check("exc_mepc", rd_data, 32'h100);
    tick();
    rd(12'h342); #2; check("exc_mcause", rd_data, 32'h2);
    check("exc_rv_drop", 32'(redirect_valid), 32'h0); tick();
    rd(12'h343); #2; check("exc_mtval", rd_data, 32'h13); tick();
    rd(12'h300); #2; check("exc_mstatus", rd_data, 32'h1800); tick();
    rd(12'h340); #2; check("exc_wr_dropped", rd_data, 32'hDEAD_BEE0); tick();

    // Vectored interrupt, MSI beats MTI, then MRET
    csr(3'd1, 12'h300, 32'h8, 5'd1); tick();
    csr(3'd1, 12'h304, 32'h888, 5'd1); tick();
    csr(3'd1, 12'h305, 32'h401, 5'd1); tick();
    msip = 1'b1; mtip = 1'b1; irq_ok = 1'b1; exc_pc = 32'h300;
    rd(12'h344); #2; check("mip", rd_data, 32'h88); tick();
    rd(12'h342); #2;
    check("irq_rv", 32'(redirect_valid), 32'h1);
    check("irq_rpc", redirect_pc, 32'h40C);
    check("irq_mcause", rd_data, 32'h8000_0003);
    tick();
    rd(12'h300); #2; check("irq_mstatus", rd_data, 32'h1880); tick();
    rd(12'h341); #2; check("irq_mepc", rd_data, 32'h300); tick();
    mret = 1'b1; tick();
    rd(12'h300); #2;
    check("mret_rv", 32'(redirect_valid), 32'h1);
    check("mret_rpc", redirect_pc, 32'h300);
    check("mret_mstatus", rd_data, 32'h1888);
    tick();

    // 64-bit counter carry and write-over-increment
    csr(3'd1, 12'hB80, 32'h0, 5'd1); tick();
    csr(3'd1, 12'hB00, 32'hFFFF_FFFF, 5'd1); tick();
    rd(12'hB00); #2; check("mcycle_written", rd_data, 32'hFFFF_FFFF); tick();
    rd(12'hB80); #2; check("mcycleh_carry", rd_data, 32'h1); tick();
    rd(12'hB00); #2; check("mcycle_wrapped", rd_data, 32'h1); tick();
    csr(3'd1, 12'hB02, 32'h50, 5'd1); instret = 1'b1; tick();
    rd(12'hB02); #2; check("minstret_hold", rd_data, 32'h50); tick();

    // Reset while a redirect is pending
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h44; tick();
    rst = 1'b0; model_reset();
    rd(12'h305); #2;
    check("rst_mid_rv", 32'(redirect_valid), 32'h0);
    check("rst_mid_mtvec", rd_data, 32'h100);
    tick();
    rst = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      csr_en    = ($urandom_range(0, 1) == 0);
      csr_op    = 3'($urandom_range(0, 7));
      csr_addr  = addrs[$urandom_range(0, 20)];
      rs1_data  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      src_idx   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      instret   = 1'($urandom_range(0, 1));
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_cause = 4'($urandom_range(0, 15));
      exc_pc    = $urandom;
      exc_tval  = $urandom;
      irq_ok    = 1'($urandom_range(0, 1));
      mret      = ($urandom_range(0, 9) == 0);
      meip      = ($urandom_range(0, 3) == 0);
      msip      = ($urandom_range(0, 3) == 0);
      mtip      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
